// File: rtl/game_flow_ctrl_pkg.sv
// Shared types and constants for the game sequencer slice.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_COUNTDOWN = 2'd1,
      ST_PLAYING   = 2'd2,
      ST_OVER      = 2'd3
   } game_state_t;

   localparam logic [1:0] DIFF_EASY = 2'd1;
   localparam logic [1:0] DIFF_MED  = 2'd2;
   localparam logic [1:0] DIFF_HARD = 2'd3;

   localparam int DEF_COUNT_FRAMES = 3;
   localparam int DEF_OVER_FRAMES  = 60;
   localparam int DEF_LVL2_SCORE   = 20;
   localparam int DEF_LVL3_SCORE   = 40;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Control/status bundle between input logic, the sequencer and score_engine.
interface game_flow_ctrl_if;
   logic        btn_start;
   logic        collision;
   logic [31:0] score;
   logic        start;
   logic [1:0]  difficulty;
   logic        game_over;
   logic [31:0] high_score;
   logic [31:0] final_score;
   logic [1:0]  state;

   modport master (
      output btn_start, collision, score,
      input  start, difficulty, game_over, high_score, final_score, state
   );

   modport slave (
      input  btn_start, collision, score,
      output start, difficulty, game_over, high_score, final_score, state
   );
endinterface

// File: rtl/game_flow_ctrl_difficulty_ramp.sv
// Monotonic difficulty ramp driven by the live score while playing.
module difficulty_ramp
   import game_pkg::*;
#(
   parameter int LVL2_SCORE = DEF_LVL2_SCORE,
   parameter int LVL3_SCORE = DEF_LVL3_SCORE
) (
   input  logic        clock_div,
   input  logic        reset_n,
   input  logic [31:0] score,
   input  logic        enable,
   input  logic        clear,
   output logic [1:0]  difficulty
);

   localparam logic [31:0] L2 = 32'(LVL2_SCORE);
   localparam logic [31:0] L3 = 32'(LVL3_SCORE);

   // Clear wins; otherwise only ever step upward so a score drop never eases the game.
   always_ff @(posedge clock_div or negedge reset_n) begin
      if (!reset_n) begin
         difficulty <= DIFF_EASY;
      end else if (clear) begin
         difficulty <= DIFF_EASY;
      end else if (enable) begin
         if (score >= L3)
            difficulty <= DIFF_HARD;
         else if (score >= L2 && difficulty < DIFF_MED)
            difficulty <= DIFF_MED;
      end
   end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game life-cycle sequencer: idle -> countdown -> playing -> over, with high-score latch.
module game_flow_ctrl
   import game_pkg::*;
#(
   parameter int COUNT_FRAMES = DEF_COUNT_FRAMES,
   parameter int OVER_FRAMES  = DEF_OVER_FRAMES,
   parameter int LVL2_SCORE   = DEF_LVL2_SCORE,
   parameter int LVL3_SCORE   = DEF_LVL3_SCORE
) (
   input  logic            clock_div,
   input  logic            reset_n,
   game_flow_ctrl_if.slave gif
);

   // One down-counter serves both the countdown and the game-over hold.
   localparam int MAXF  = max_i(COUNT_FRAMES, OVER_FRAMES);
   localparam int CNT_W = (MAXF > 1) ? $clog2(MAXF) : 1;
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(COUNT_FRAMES - 1);
   localparam logic [CNT_W-1:0] CNT_OVER  = CNT_W'(OVER_FRAMES - 1);

   game_state_t      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             start_q;
   logic             go_q;
   logic [31:0]      final_q;
   logic [31:0]      high_q;
   logic             ramp_en;
   logic             ramp_clr;

   // Difficulty falls back to easy whenever the next state is IDLE or COUNTDOWN.
   always_comb begin
      ramp_en  = (state_q == ST_PLAYING);
      ramp_clr = (state_q == ST_IDLE) ||
                 ((state_q == ST_OVER) && (gif.btn_start || cnt_q == '0));
   end

   // Main FSM with registered outputs, shared counter and score latches.
   always_ff @(posedge clock_div or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         start_q <= 1'b0;
         go_q    <= 1'b0;
         final_q <= '0;
         high_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               start_q <= 1'b0;
               go_q    <= 1'b0;
               if (gif.btn_start) begin
                  state_q <= ST_COUNTDOWN;
                  cnt_q   <= CNT_START;
               end
            end
            ST_COUNTDOWN: begin
               if (cnt_q == '0) begin
                  state_q <= ST_PLAYING;
                  start_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_PLAYING: begin
               start_q <= 1'b1;
               // Collision is the only exit; btn_start has no effect here.
               if (gif.collision) begin
                  state_q <= ST_OVER;
                  start_q <= 1'b0;
                  go_q    <= 1'b1;
                  final_q <= gif.score;
                  cnt_q   <= CNT_OVER;
                  if (gif.score > high_q)
                     high_q <= gif.score;
               end
            end
            ST_OVER: begin
               if (gif.btn_start) begin
                  state_q <= ST_COUNTDOWN;
                  go_q    <= 1'b0;
                  cnt_q   <= CNT_START;
               end else if (cnt_q == '0) begin
                  state_q <= ST_IDLE;
                  go_q    <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               start_q <= 1'b0;
               go_q    <= 1'b0;
            end
         endcase
      end
   end

   difficulty_ramp #(
      .LVL2_SCORE (LVL2_SCORE),
      .LVL3_SCORE (LVL3_SCORE)
   ) u_ramp (
      .clock_div  (clock_div),
      .reset_n    (reset_n),
      .score      (gif.score),
      .enable     (ramp_en),
      .clear      (ramp_clr),
      .difficulty (gif.difficulty)
   );

   assign gif.state       = state_q;
   assign gif.start       = start_q;
   assign gif.game_over   = go_q;
   assign gif.final_score = final_q;
   assign gif.high_score  = high_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: vector table through a scoreboard queue.
module tb_game_flow_ctrl;

   typedef struct {
      logic        btn;
      logic        coll;
      logic [31:0] score;
      logic [1:0]  st;
      logic        start;
      logic [1:0]  diff;
      logic        go;
      logic [31:0] fin;
      logic [31:0] hi;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   int   vidx;
   vec_t tbl[$];
   vec_t sb[$];

   game_flow_ctrl_if gif ();

   game_flow_ctrl #(
      .COUNT_FRAMES (3),
      .OVER_FRAMES  (4),
      .LVL2_SCORE   (20),
      .LVL3_SCORE   (40)
   ) dut (
      .clock_div (clk),
      .reset_n   (rst_n),
      .gif       (gif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic b, input logic c, input int s,
                               input int st, input logic stt, input int d,
                               input logic go, input int fin, input int hi);
      vec_t v;
      v.btn = b; v.coll = c; v.score = 32'(s);
      v.st = 2'(st); v.start = stt; v.diff = 2'(d); v.go = go;
      v.fin = 32'(fin); v.hi = 32'(hi);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input vec_t e);
      chk({tag, " state"},       32'(gif.state),      32'(e.st));
      chk({tag, " start"},       32'(gif.start),      32'(e.start));
      chk({tag, " difficulty"},  32'(gif.difficulty), 32'(e.diff));
      chk({tag, " game_over"},   32'(gif.game_over),  32'(e.go));
      chk({tag, " final_score"}, gif.final_score,     e.fin);
      chk({tag, " high_score"},  gif.high_score,      e.hi);
   endtask

   // Drive one frame of inputs, queue the expectation, compare after the edge.
   task automatic step(input vec_t v);
      vec_t e;
      @(negedge clk);
      gif.btn_start = v.btn;
      gif.collision = v.coll;
      gif.score     = v.score;
      sb.push_back(v);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard: got empty queue expected entry");
      end else begin
         e = sb.pop_front();
         chk_all($sformatf("v%0d", vidx), e);
      end
      vidx++;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; vidx = 0;
      rst_n = 1'b0;
      gif.btn_start = 1'b0;
      gif.collision = 1'b0;
      gif.score     = '0;

      //            btn coll score  st start diff go fin hi
      tbl.push_back(mk(1, 0,  0,    1, 0, 1, 0,  0,  0));  // start sampled
      tbl.push_back(mk(0, 0,  0,    1, 0, 1, 0,  0,  0));
      tbl.push_back(mk(0, 0,  0,    1, 0, 1, 0,  0,  0));
      tbl.push_back(mk(0, 1,  0,    2, 1, 1, 0,  0,  0));  // collision ignored in countdown
      tbl.push_back(mk(0, 0, 19,    2, 1, 1, 0,  0,  0));
      tbl.push_back(mk(0, 0, 20,    2, 1, 2, 0,  0,  0));
      tbl.push_back(mk(0, 0, 39,    2, 1, 2, 0,  0,  0));
      tbl.push_back(mk(0, 0, 40,    2, 1, 3, 0,  0,  0));
      tbl.push_back(mk(0, 0, 45,    2, 1, 3, 0,  0,  0));
      tbl.push_back(mk(0, 0, 10,    2, 1, 3, 0,  0,  0));  // no decrease
      tbl.push_back(mk(1, 0, 37,    2, 1, 3, 0,  0,  0));  // btn ignored while playing
      tbl.push_back(mk(0, 1, 37,    3, 0, 3, 1, 37, 37));
      tbl.push_back(mk(0, 0, 37,    3, 0, 3, 1, 37, 37));
      tbl.push_back(mk(0, 0, 37,    3, 0, 3, 1, 37, 37));
      tbl.push_back(mk(0, 0, 37,    3, 0, 3, 1, 37, 37));
      tbl.push_back(mk(0, 0, 37,    0, 0, 1, 0, 37, 37));  // 4 frames -> idle
      tbl.push_back(mk(1, 0,  0,    1, 0, 1, 0, 37, 37));  // game 2
      tbl.push_back(mk(0, 0,  0,    1, 0, 1, 0, 37, 37));
      tbl.push_back(mk(0, 0,  0,    1, 0, 1, 0, 37, 37));
      tbl.push_back(mk(0, 0,  0,    2, 1, 1, 0, 37, 37));
      tbl.push_back(mk(0, 0, 25,    2, 1, 2, 0, 37, 37));
      tbl.push_back(mk(0, 1, 25,    3, 0, 2, 1, 25, 37));  // lower score keeps high
      tbl.push_back(mk(1, 0, 25,    1, 0, 1, 0, 25, 37));  // restart from over
      tbl.push_back(mk(0, 0,  0,    1, 0, 1, 0, 25, 37));
      tbl.push_back(mk(0, 0,  0,    1, 0, 1, 0, 25, 37));
      tbl.push_back(mk(0, 0,  0,    2, 1, 1, 0, 25, 37));
      tbl.push_back(mk(0, 0, 37,    2, 1, 2, 0, 25, 37));
      tbl.push_back(mk(1, 1, 37,    3, 0, 2, 1, 37, 37));  // collision beats btn; equal no update
      tbl.push_back(mk(0, 0, 50,    3, 0, 2, 1, 37, 37));

      // Reset state, checked while reset is still held.
      #12;
      chk_all("reset", mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) step(tbl[i]);

      // New best score, then async reset in the middle of play.
      step(mk(1, 0,  0,  1, 0, 1, 0, 37, 37));
      step(mk(0, 0,  0,  1, 0, 1, 0, 37, 37));
      step(mk(0, 0,  0,  1, 0, 1, 0, 37, 37));
      step(mk(0, 0,  0,  2, 1, 1, 0, 37, 37));
      step(mk(0, 0, 50,  2, 1, 3, 0, 37, 37));
      step(mk(0, 1, 50,  3, 0, 3, 1, 50, 50));
      step(mk(1, 0,  0,  1, 0, 1, 0, 50, 50));
      step(mk(0, 0,  0,  1, 0, 1, 0, 50, 50));
      step(mk(0, 0,  0,  1, 0, 1, 0, 50, 50));
      step(mk(0, 0, 45,  2, 1, 1, 0, 50, 50));
      step(mk(0, 0, 45,  2, 1, 3, 0, 50, 50));

      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
      @(posedge clk);
      #1;
      chk_all("rst_held", mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      step(mk(1, 0, 0, 1, 0, 1, 0, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
